// File: rtl/nibbler_mem_pkg.sv
// ----------------------------------------------------------------------------
// nibbler_mem_pkg: shared types and constants for the nibble RAM path. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package nibbler_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Both operands are already below n, so one conditional subtract wraps.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker: combinational round-robin search starting at rr_ptr. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);
  import nibbler_mem_pkg::*;

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand     = rr_wrap(32'(rr_ptr) + 32'(k), 32'(N_REQ));
      cand_idx = cand[IDX_W-1:0];
      if (req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter: round-robin sharing of the nibble RAM between N_REQ requesters. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ram_arbiter #(
  parameter int N_REQ         = 2,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 4,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  inout  wire  [DATA_W-1:0]         ram_data
);
  import nibbler_mem_pkg::*;

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t        state_q,  state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q,  grant_d;
  logic              we_q,     we_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] wdata_q,  wdata_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [N_REQ-1:0]  ack_q,    ack_d;
  logic [DATA_W-1:0] rdata_q,  rdata_d;
  logic              busy_q,   busy_d;

  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  int unsigned       next_ptr;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req         (req),
    .rr_ptr      (rr_ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Mux the grantee's fields out of the flattened buses with constant slices.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ram_cs_d = ram_cs_q;
    ram_we_d = ram_we_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    next_ptr = rr_wrap(32'(grant_q) + 32'd1, 32'(N_REQ));

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant_d  = grant_idx;
          we_d     = req_we[grant_idx];
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          cnt_d    = '0;
          ram_cs_d = 1'b1;
          ram_we_d = req_we[grant_idx];
          busy_d   = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) begin
            rdata_d = ram_data;
          end
          ram_cs_d       = 1'b0;
          ram_we_d       = 1'b0;
          cnt_d          = '0;
          ack_d[grant_q] = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = next_ptr[IDX_W-1:0];
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ram_cs_q <= 1'b0;
      ram_we_q <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ram_cs_q <= ram_cs_d;
      ram_we_q <= ram_we_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = addr_q;

  // Drive enable comes only from flops, so the bus never glitches on.
  assign ram_data = (state_q == ACCESS && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  int          cyc   = 0;
  int          checks = 0;
  int          failures = 0;
  int          ack_seen = 0;

  // Instance with single-cycle access
  logic [1:0]  req, req_we;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic [1:0]  ack;
  logic [3:0]  rdata;
  logic        busy, ram_cs, ram_we;
  logic [11:0] ram_addr;
  wire  [3:0]  ram_data;
  logic [3:0]  mem [0:4095];

  // Instance with three-cycle access
  logic [1:0]  d3_req, d3_req_we;
  logic [23:0] d3_req_addr;
  logic [7:0]  d3_req_wdata;
  logic [1:0]  d3_ack;
  logic [3:0]  d3_rdata;
  logic        d3_busy, d3_cs, d3_we;
  logic [11:0] d3_addr;
  wire  [3:0]  d3_data;
  logic [3:0]  d3_mem [0:4095];

  typedef struct {
    int         idx;
    logic [3:0] rdata;
    bit         is_read;
    int         exp_cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.N_REQ(2), .ADDR_W(12), .DATA_W(4), .ACCESS_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  ram_arbiter #(.N_REQ(2), .ADDR_W(12), .DATA_W(4), .ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .req(d3_req), .req_we(d3_req_we), .req_addr(d3_req_addr),
    .req_wdata(d3_req_wdata), .ack(d3_ack), .rdata(d3_rdata), .busy(d3_busy),
    .ram_cs(d3_cs), .ram_we(d3_we), .ram_addr(d3_addr), .ram_data(d3_data)
  );

  // Pull-ups make a released bus read as 4'hF.
  for (genvar b = 0; b < 4; b++) begin : g_pu
    pullup (ram_data[b]);
    pullup (d3_data[b]);
  end

  assign ram_data = (ram_cs && !ram_we) ? mem[ram_addr] : 4'bz;
  assign d3_data  = (d3_cs && !d3_we) ? d3_mem[d3_addr] : 4'bz;

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[12'h001] <= 4'b1100;
      mem[12'h002] <= 4'b0110;
      mem[12'h0FF] <= 4'b0111;
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    if (d3_cs && d3_we) d3_mem[d3_addr] <= d3_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    for (int k = 0; k < 40 && ack_seen < n; k++) tick();
    check("ack_timeout", 32'(ack_seen >= n), 32'd1);
  endtask

  // Monitor: every ack pops one expectation from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack != 2'b00) begin
        exp_t e;
        ack_seen++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_vec", 32'(ack), 32'(2'b01 << e.idx));
          check("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
          if (e.is_read) check("rdata", 32'(rdata), 32'(e.rdata));
        end
      end
      if (ram_we) check("we_without_cs", 32'(ram_cs), 32'd1);
    end
  end

  task automatic set_req(input int i, input bit we, input logic [11:0] a, input logic [3:0] d);
    req[i]               = 1'b1;
    req_we[i]            = we;
    req_addr[i*12 +: 12] = a;
    req_wdata[i*4 +: 4]  = d;
  endtask

  task automatic push_exp(input int i, input logic [3:0] rd, input bit is_read, input int at);
    exp_t e;
    e.idx = i; e.rdata = rd; e.is_read = is_read; e.exp_cyc = at;
    sb.push_back(e);
  endtask

  // One transaction on the single-cycle instance, issued while it is idle.
  task automatic xact(input int i, input bit we, input logic [11:0] a, input logic [3:0] d,
                      input logic [3:0] exp_rd, input logic [11:0] a_late);
    int n;
    tick();
    set_req(i, we, a, d);
    push_exp(i, exp_rd, !we, cyc + 2);
    n = ack_seen + 1;
    tick();
    check("acc_cs", 32'(ram_cs), 32'd1);
    check("acc_we", 32'(ram_we), 32'(we));
    check("acc_addr", 32'(ram_addr), 32'(a));
    check("acc_busy", 32'(busy), 32'd1);
    if (we) check("acc_wdata", 32'(ram_data), 32'(d));
    req_addr[i*12 +: 12] = a_late;
    wait_acks(n);
    check("hold_addr", 32'(ram_addr), 32'(a));
    check("resp_cs", 32'(ram_cs), 32'd0);
    check("resp_bus", 32'(ram_data), 32'hF);
    req[i] = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cs"}, 32'(ram_cs), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_bus"}, 32'(ram_data), 32'hF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    // 1: reset with random requests
    req = 2'($urandom); req_we = 2'($urandom);
    req_addr = 24'($urandom); req_wdata = 8'($urandom);
    d3_req = '0; d3_req_we = '0; d3_req_addr = '0; d3_req_wdata = '0;
    tick();
    reset_checks("rst1");
    req = 2'($urandom); req_addr = 24'($urandom);
    tick();
    reset_checks("rst2");
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b0;

    // 2: write then read back through requester 0
    xact(0, 1'b1, 12'h000, 4'b0011, 4'b0000, 12'h000);
    xact(0, 1'b0, 12'h000, 4'b0000, 4'b0011, 12'h000);

    // 3: reset to rr_ptr=0, then two requesters held continuously
    tick(); reset = 1'b1;
    tick(); tick(); reset = 1'b0;
    tick();
    set_req(0, 1'b0, 12'h001, 4'h0);
    set_req(1, 1'b0, 12'h002, 4'h0);
    base = cyc + 2;
    push_exp(0, 4'b1100, 1'b1, base);
    push_exp(1, 4'b0110, 1'b1, base + 3);
    push_exp(0, 4'b1100, 1'b1, base + 6);
    push_exp(1, 4'b0110, 1'b1, base + 9);
    wait_acks(ack_seen + 4);
    req = '0;

    // 5: move rr_ptr to 1, abort a write with reset, then contend
    xact(0, 1'b0, 12'h002, 4'h0, 4'b0110, 12'h002);
    tick();
    set_req(1, 1'b1, 12'h010, 4'b0101);
    tick();
    check("abort_acc_cs", 32'(ram_cs), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_cs", 32'(ram_cs), 32'd0);
    check("abort_we", 32'(ram_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bus", 32'(ram_data), 32'hF);
    req = '0;
    reset = 1'b0;
    tick();
    set_req(0, 1'b0, 12'h001, 4'h0);
    set_req(1, 1'b0, 12'h002, 4'h0);
    base = cyc + 2;
    push_exp(0, 4'b1100, 1'b1, base);
    push_exp(1, 4'b0110, 1'b1, base + 3);
    wait_acks(ack_seen + 2);
    req = '0;

    // 6: address change after the grant is ignored
    xact(0, 1'b0, 12'h001, 4'h0, 4'b1100, 12'h0FF);

    // 4: three-cycle access window on the second instance
    tick();
    d3_req[0] = 1'b1; d3_req_we[0] = 1'b1;
    d3_req_addr[11:0] = 12'h002; d3_req_wdata[3:0] = 4'b1010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("w3_cs", 32'(d3_cs), 32'd1);
      check("w3_we", 32'(d3_we), 32'd1);
      check("w3_addr", 32'(d3_addr), 32'h002);
      check("w3_data", 32'(d3_data), 32'b1010);
      check("w3_noack", 32'(d3_ack), 32'd0);
    end
    tick();
    check("w3_ack", 32'(d3_ack), 32'b01);
    check("w3_cs_off", 32'(d3_cs), 32'd0);
    check("w3_bus_off", 32'(d3_data), 32'hF);
    d3_req = '0;
    tick();
    check("w3_ack_pulse", 32'(d3_ack), 32'd0);
    check("w3_mem", 32'(d3_mem[12'h002]), 32'b1010);

    n = 0;
    repeat (4) tick();
    n = sb.size();
    check("sb_drain", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
